// File: rtl/mem_access.sv
// mem_access: pipeline memory stage between execute and writeback.
//
// Accepts one instruction per cycle from execute. Loads and stores are issued
// to the data memory over a req/gnt/rvalid handshake; big-endian load data is
// shifted into MSB-justified form and registered into MEM/WB. Upstream is
// stalled while a memory transaction is outstanding.
//
// Handshake: dmem_req is asserted with stable dmem_we/addr/be/wdata until the
// cycle dmem_gnt is seen high (request accepted at that edge). A granted load
// then waits in WAIT with dmem_req low until dmem_rvalid, whose dmem_rdata is
// captured at that edge. dmem_rvalid outside WAIT is ignored. Upstream holds all
// in_* stable in every cycle stall is high.
//
// Ports:
//   clk, rst_n          stage clock, asynchronous active-low reset
//   in_*                instruction from execute (address = in_alu_out)
//   stall               upstream must hold in_* this cycle
//   dmem_*              data memory request/response
//   wb_*, misaligned    registered MEM/WB outputs
//   dbg_state           current FSM state (0 IDLE, 1 REQ, 2 WAIT)
//
// Build option: define MEM_ALIGN_TRAP_EN to trap misaligned half/word accesses
// (no memory request, misaligned=1). Undefined: low address bits are forced to
// alignment and misaligned is tied to 0.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  in_rw_d,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_insn,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_mem_read_size,
  input  logic        in_mem_sign_extend,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [1:0]  wb_rw_d,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_data_out,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_insn,
  output logic [1:0]  wb_mem_read_size,
  output logic        wb_mem_sign_extend,
  output logic        misaligned,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic       mem_op;
  logic       is_half, is_byte, is_word;
  logic [1:0] off;
  logic [1:0] eff_off;
  logic       misalign_c;
  logic       do_mem;
  logic       complete;
  logic       fire;
  logic       is_load;

  assign mem_op  = in_mem_read | in_mem_write;
  assign is_half = (in_mem_read_size == 2'd1);
  assign is_byte = (in_mem_read_size == 2'd2);
  // Size encoding 3 is unused; treat it as a word access.
  assign is_word = ~is_half & ~is_byte;
  assign off     = in_alu_out[1:0];
  // Offset after forcing alignment: halves keep only bit 1, words use 0.
  assign eff_off = is_byte ? off : (is_half ? {off[1], 1'b0} : 2'b00);
  assign is_load = in_mem_read & ~in_mem_write;

`ifdef MEM_ALIGN_TRAP_EN
  assign misalign_c = mem_op & ((is_half & off[0]) | (is_word & (off != 2'b00)));
`else
  assign misalign_c = 1'b0;
`endif

  assign do_mem = in_valid & mem_op & ~misalign_c;

  // Next state, request strobe and completion.
  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE, S_REQ: begin
        if (do_mem) begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            if (in_mem_write) begin
              complete = 1'b1;
              state_d  = S_IDLE;
            end else begin
              state_d  = S_WAIT;
            end
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall = do_mem & ~complete;
  // Instruction leaves the stage this cycle: non-memory, trapped, or completed.
  assign fire  = in_valid & (~mem_op | misalign_c | complete);

  // Request payload is zero whenever no request is driven.
  always_comb begin
    dmem_we    = 1'b0;
    dmem_addr  = 32'd0;
    dmem_be    = 4'b0000;
    dmem_wdata = 32'd0;
    if (dmem_req) begin
      dmem_we   = in_mem_write;
      dmem_addr = {in_alu_out[31:2], 2'b00};
      if (is_byte) begin
        dmem_be    = 4'b1000 >> eff_off;
        dmem_wdata = {4{in_store_data[7:0]}};
      end else if (is_half) begin
        dmem_be    = eff_off[1] ? 4'b0011 : 4'b1100;
        dmem_wdata = {2{in_store_data[15:0]}};
      end else begin
        dmem_be    = 4'b1111;
        dmem_wdata = in_store_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign dbg_state = state_q;

  // MEM/WB register. A stalled cycle inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid           <= 1'b0;
      wb_rw_d            <= 2'd0;
      wb_alu_out         <= 32'd0;
      wb_data_out        <= 32'd0;
      wb_pc              <= 32'd0;
      wb_insn            <= 32'd0;
      wb_mem_read_size   <= 2'd0;
      wb_mem_sign_extend <= 1'b0;
    end else begin
      wb_valid <= fire;
      if (fire) begin
        wb_rw_d            <= in_rw_d;
        wb_alu_out         <= in_alu_out;
        wb_pc              <= in_pc;
        wb_insn            <= in_insn;
        wb_mem_read_size   <= in_mem_read_size;
        wb_mem_sign_extend <= in_mem_sign_extend;
        // Big-endian: shifting left by the byte offset MSB-justifies the lane.
        wb_data_out        <= (is_load & ~misalign_c) ?
                              (dmem_rdata << {eff_off, 3'b000}) : 32'd0;
      end
    end
  end

`ifdef MEM_ALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned <= 1'b0;
    else        misaligned <= fire & misalign_c;
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: doc/mem_access.md
# mem_access

Pipeline memory stage between execute and writeback. Accepts one instruction per cycle from execute and issues loads/stores to the data memory over a request/grant/response handshake. Aligns big-endian load data into the MSB-justified form writeback expects. Registers the result into the MEM/WB pipeline register and stalls upstream while a memory transaction is outstanding.

## Interface
- No parameters; data and address width fixed at 32.
- clk  in  1  stage clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute presents a valid instruction
- in_rw_d  in  2  writeback select: 0 ALU, 1 memory, 2 PC
- in_alu_out  in  32  ALU result; effective address for loads/stores
- in_store_data  in  32  rt value for stores
- in_pc, in_insn  in  32 each  passed through
- in_mem_read, in_mem_write  in  1 each  load / store instruction
- in_mem_read_size  in  2  access size for loads and stores: 0 word, 1 half, 2 byte
- in_mem_sign_extend  in  1  passed through to writeback
- stall  out  1  upstream must hold all in_* this cycle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables; be[3] = bits [31:24]
- dmem_wdata  out  32  store data, replicated across lanes
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data, full word
- wb_valid  out  1  MEM/WB register holds a valid instruction
- wb_rw_d, wb_alu_out, wb_data_out, wb_pc, wb_insn, wb_mem_read_size, wb_mem_sign_extend  out  registered to writeback
- misaligned  out  1  registered trap flag (only with MEM_ALIGN_TRAP_EN)

## Operation
- Big-endian: byte offset off = addr[1:0]; offset 0 is bits [31:24].
- Store lanes: word be=1111; half be=1100 (off 0) / 0011 (off 2); byte be=1000>>off. Store data: word as is; half {2{d[15:0]}}; byte {4{d[7:0]}}.
- Load alignment: wb_data_out = dmem_rdata << (8*off). The addressed half lands in [31:16], the addressed byte in [31:24].
- FSM states:
  - IDLE
    - No memory op: if in_valid, load MEM/WB at the edge; otherwise wb_valid=0.
    - Memory op: drive dmem_req. On gnt, a store completes (MEM/WB loaded) and a load moves to WAIT. Without gnt, move to REQ.
  - REQ: hold dmem_req with identical addr/be/wdata until gnt. Then a store completes and returns to IDLE; a load moves to WAIT.
  - WAIT: dmem_req=0. On dmem_rvalid, capture the aligned data into MEM/WB and return to IDLE.
- stall=1 whenever in_valid & (mem_read|mem_write) and the op does not complete this cycle.
  - Complete means: store with gnt, or WAIT with rvalid.
  - While stall=1, wb_valid is loaded with 0 (bubble).
- dmem_rvalid in IDLE or REQ is ignored.
- Non-load instructions load wb_data_out with 0.

## Timing
- Reset: state IDLE; all wb_* outputs, misaligned, dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are 0.
- Non-memory instruction: wb_* valid 1 cycle after acceptance.
- Store with immediate gnt: 1 cycle; each extra cycle without gnt adds 1.
- Load: wb valid on the edge at which rvalid is sampled in WAIT. Minimum 2 cycles (gnt in cycle 0, rvalid in cycle 1).
- Combinational outputs: stall and the dmem_* request signals. All wb_* outputs are registered.
- Reset mid-transaction abandons the request. Any late rvalid after reset is ignored because the FSM is in IDLE.
- One transaction outstanding at most; no new request is issued in WAIT.

## Configuration
- MEM_ALIGN_TRAP_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no dmem_req.
  - The instruction completes in 1 cycle with misaligned=1 and wb_valid=1.
- MEM_ALIGN_TRAP_EN undefined:
  - The low address bits are forced to alignment (half: off&2, word: off=0).
  - misaligned is tied to 0.

## Test plan
- Non-memory op (rw_d=0, alu_out=0x1234) → next cycle wb_valid=1, wb_alu_out=0x1234, stall never asserted.
- Store byte 0xAB to 0x103, gnt same cycle → dmem_be=0001, dmem_wdata=0xABABABAB, dmem_addr=0x100, stall=0.
- Load half from 0x102, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x1122_3344:
  - wb_data_out=0x3344_0000.
  - stall held 5 cycles, then released.
  - addr and be stable throughout REQ.
- Load byte from 0x101, rdata=0xA1B2C3D4 → wb_data_out=0xB2C3_D400, wb_mem_sign_extend passed through.
- rst_n asserted in WAIT, then rvalid pulses after release → no wb_valid, state IDLE, all outputs 0.
- With MEM_ALIGN_TRAP_EN, word load at 0x102 → dmem_req never asserted, misaligned=1 after 1 cycle.
